memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 31 +++
 rtl/memory_arbiter.sv | 84 ++++++++
 tb/tb_memory_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Instruction, data and RAM-side signals shared by the arbiter and its environment.
// The arbiter connects through 'master'; the requesters and RAM model use 'slave'.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single-ported RAM.
// One transaction at a time; request fields are latched at grant time.
module memory_arbiter #(
  parameter int unsigned ANTI_STARVE = 1
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        ren;
  } txn_t;

  logic [1:0] state, state_nxt, pick;
  txn_t       txn;
  logic       starve, memerr_q;
  logic       d_req, in_i, in_d, live, acc, err;

  assign d_req = bus.dREN | bus.dWEN;
  assign in_i  = (state == IGRANT);
  assign in_d  = (state == DGRANT);
  // A grant is only live while its requester still holds the request; dropping it aborts.
  assign live  = (in_i & bus.iREN) | (in_d & d_req);
  assign acc   = live & (bus.ramstate == RS_ACCESS);
  assign err   = live & (bus.ramstate == RS_ERROR);

  always_comb begin
    pick = IDLE;
    if (starve && bus.iREN) pick = IGRANT;
    else if (d_req)         pick = DGRANT;
    else if (bus.iREN)      pick = IGRANT;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:           state_nxt = pick;
      IGRANT, DGRANT: if (!live || acc || err) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      txn      <= '0;
      starve   <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick == DGRANT)
        txn <= '{addr: bus.daddr, data: bus.dstore, wen: bus.dWEN, ren: bus.dREN & ~bus.dWEN};
      else if (state == IDLE && pick == IGRANT)
        txn <= '{addr: bus.iaddr, data: 32'h0, wen: 1'b0, ren: 1'b1};
      if (state == IDLE && pick == IGRANT)
        starve <= 1'b0;
      else if (ANTI_STARVE != 0 && in_d && acc)
        starve <= 1'b1;
      if (err) memerr_q <= 1'b1;
    end
  end

  assign bus.ramREN   = live & txn.ren;
  assign bus.ramWEN   = live & txn.wen;
  assign bus.ramaddr  = live ? txn.addr : 32'h0;
  assign bus.ramstore = live ? txn.data : 32'h0;
  assign bus.ihit     = in_i & acc;
  assign bus.dhit     = in_d & acc;
  assign bus.iload    = (in_i & acc) ? bus.ramload : 32'h0;
  assign bus.dload    = (in_d & acc & txn.ren) ? bus.ramload : 32'h0;
  assign bus.memerr   = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// single-requester transactions checked against a per-transaction timing model.
module tb_memory_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK, nRST;
  int   total, bad;

  memory_arbiter_if bus ();
  memory_arbiter #(.ANTI_STARVE(1)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    bus.iREN = 1; bus.dREN = 1; bus.dWEN = 0; bus.iaddr = 32'h1234; bus.daddr = 32'h5678;
    bus.dstore = 32'hFFFF; bus.ramload = 32'hA5A5A5A5; bus.ramstate = ACCESS;
    #2 nRST = 1'b0;
    #1;
    total++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.memerr} !== 5'b0 ||
        bus.iload !== 0 || bus.dload !== 0 || bus.ramaddr !== 0 || bus.ramstore !== 0) begin
      bad++; $display("FAIL reset_outputs got=%b addr=%h want all zero",
        {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.memerr}, bus.ramaddr);
    end
    @(negedge CLK); @(negedge CLK); #1;
    total++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.memerr} !== 5'b0) begin
      bad++; $display("FAIL reset_held got=%b want=00000",
        {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.memerr});
    end
    do_reset();
  endtask

  task automatic test_ifetch();
    do_reset();
    @(negedge CLK); bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY; #1;
    total++;
    if (bus.ramREN !== 1'b0) begin bad++; $display("FAIL ifetch_arb ramREN got=%b want=0", bus.ramREN); end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (c == 2) begin bus.ramstate = ACCESS; bus.ramload = 32'h8C220004; end
      #1;
      total++;
      if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== {3'b10, (c == 2), 1'b0} ||
          bus.ramaddr !== 32'h40) begin
        bad++; $display("FAIL ifetch_grant c=%0d got=%b addr=%h want=%b addr=40", c,
          {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, bus.ramaddr, {3'b10, (c == 2), 1'b0});
      end
    end
    total++;
    if (bus.iload !== 32'h8C220004) begin bad++; $display("FAIL ifetch_iload got=%h want=8c220004", bus.iload); end
    @(negedge CLK); bus.iREN = 0; bus.ramstate = FREE; #1;
    total++;
    if ({bus.ramREN, bus.ihit} !== 2'b00 || bus.iload !== 0) begin
      bad++; $display("FAIL ifetch_after got=%b iload=%h want=00 0", {bus.ramREN, bus.ihit}, bus.iload);
    end
  endtask

  task automatic test_dual();
    do_reset();
    @(negedge CLK);
    bus.iREN = 1; bus.iaddr = 32'h44; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
    bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D;
    @(negedge CLK); #1;
    total++;
    if ({bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN} !== 4'b1010 || bus.ramaddr !== 32'h100 ||
        bus.ramstore !== 32'hDEAD) begin
      bad++; $display("FAIL dual_data got=%b addr=%h st=%h want=1010 100 dead",
        {bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN}, bus.ramaddr, bus.ramstore);
    end
    @(negedge CLK); #1;
    total++;
    if ({bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN} !== 4'b0000) begin
      bad++; $display("FAIL dual_gap got=%b want=0000", {bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN});
    end
    @(negedge CLK); bus.dWEN = 0; #1;
    total++;
    if ({bus.ihit, bus.dhit} !== 2'b10 || bus.ramaddr !== 32'h44 || bus.iload !== 32'h0BADF00D) begin
      bad++; $display("FAIL dual_ifetch_second got=%b addr=%h iload=%h want=10 44 0badf00d",
        {bus.ihit, bus.dhit}, bus.ramaddr, bus.iload);
    end
    @(negedge CLK); idle_inputs();
  endtask

  task automatic test_rw_both();
    do_reset();
    @(negedge CLK); bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h77;
    bus.ramstate = BUSY; bus.ramload = 32'h12345678;
    @(negedge CLK); #1;
    total++;
    if ({bus.ramWEN, bus.ramREN, bus.dhit} !== 3'b100) begin
      bad++; $display("FAIL rwboth_busy got=%b want=100", {bus.ramWEN, bus.ramREN, bus.dhit});
    end
    @(negedge CLK); bus.ramstate = ACCESS; #1;
    total++;
    if ({bus.ramWEN, bus.ramREN, bus.dhit} !== 3'b101 || bus.dload !== 0) begin
      bad++; $display("FAIL rwboth_access got=%b dload=%h want=101 0",
        {bus.ramWEN, bus.ramREN, bus.dhit}, bus.dload);
    end
    @(negedge CLK); idle_inputs();
  endtask

  task automatic test_error();
    do_reset();
    @(negedge CLK); bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = ERROR;
    @(negedge CLK); #1;
    total++;
    if ({bus.dhit, bus.ramREN} !== 2'b01) begin
      bad++; $display("FAIL err_grant got=%b want=01", {bus.dhit, bus.ramREN});
    end
    @(negedge CLK); bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D; #1;
    total++;
    if ({bus.memerr, bus.dhit, bus.ramREN} !== 3'b100) begin
      bad++; $display("FAIL err_sticky_idle got=%b want=100", {bus.memerr, bus.dhit, bus.ramREN});
    end
    @(negedge CLK); #1;
    total++;
    if ({bus.memerr, bus.dhit} !== 2'b11 || bus.dload !== 32'hCAFEF00D || bus.ramaddr !== 32'h300) begin
      bad++; $display("FAIL err_retry got=%b dload=%h addr=%h want=11 cafef00d 300",
        {bus.memerr, bus.dhit}, bus.dload, bus.ramaddr);
    end
    @(negedge CLK); idle_inputs(); @(negedge CLK); #1;
    total++;
    if (bus.memerr !== 1'b1) begin bad++; $display("FAIL err_kept got=%b want=1", bus.memerr); end
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge CLK); bus.dREN = 1; bus.daddr = 32'h400; bus.ramstate = BUSY;
    @(negedge CLK); #1;
    total++;
    if ({bus.ramREN, bus.dhit} !== 2'b10 || bus.ramaddr !== 32'h400) begin
      bad++; $display("FAIL abort_grant got=%b addr=%h want=10 400", {bus.ramREN, bus.dhit}, bus.ramaddr);
    end
    @(negedge CLK); bus.dREN = 0;
    @(negedge CLK); bus.ramstate = ACCESS; #1;
    total++;
    if ({bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit} !== 4'b0 || bus.ramaddr !== 0 || bus.ramstore !== 0) begin
      bad++; $display("FAIL abort_idle got=%b addr=%h want=0000 0",
        {bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit}, bus.ramaddr);
    end
    @(negedge CLK); idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge CLK); bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
    @(negedge CLK); #1;
    total++;
    if (bus.ramREN !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b want=1", bus.ramREN); end
    #2 nRST = 1'b0;
    #1;
    total++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.memerr} !== 5'b0 || bus.ramaddr !== 0) begin
      bad++; $display("FAIL areset_immediate got=%b addr=%h want=00000 0",
        {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.memerr}, bus.ramaddr);
    end
    @(negedge CLK); nRST = 1'b1; bus.ramstate = ACCESS; bus.ramload = 32'h600D; #1;
    total++;
    if ({bus.ramREN, bus.ihit} !== 2'b00) begin
      bad++; $display("FAIL areset_rearb got=%b want=00", {bus.ramREN, bus.ihit});
    end
    @(negedge CLK); #1;
    total++;
    if ({bus.ramREN, bus.ihit} !== 2'b11 || bus.iload !== 32'h600D) begin
      bad++; $display("FAIL areset_refetch got=%b iload=%h want=11 600d", {bus.ramREN, bus.ihit}, bus.iload);
    end
    @(negedge CLK); idle_inputs();
  endtask

  // Model: a lone request of kind k is granted one cycle after it appears, holds the
  // captured fields through any FREE/BUSY wait cycles and completes on the ACCESS cycle.
  task automatic test_random();
    do_reset();
    for (int t = 0; t < 60; t++) begin
      int unsigned kind, waits, gap;
      logic [31:0] a, d, ld;
      logic        xr, xw;
      kind = $urandom_range(0, 2); waits = $urandom_range(0, 3); gap = $urandom_range(0, 2);
      a = $urandom; d = (kind == 0) ? 32'h0 : $urandom;
      xr = (kind != 2); xw = (kind == 2);
      repeat (gap) @(negedge CLK);
      @(negedge CLK);
      bus.iREN = (kind == 0); bus.iaddr = a;
      bus.dREN = (kind == 1) | ((kind == 2) & 1'($urandom_range(0, 1)));
      bus.dWEN = (kind == 2); bus.daddr = a; bus.dstore = d; bus.ramstate = ACCESS;
      #1;
      total++;
      if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== 4'b0) begin
        bad++; $display("FAIL rnd_arb t=%0d got=%b want=0000", t, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit});
      end
      for (int j = 0; j <= int'(waits); j++) begin
        logic done;
        done = (j == int'(waits));
        @(negedge CLK);
        ld = $urandom;
        bus.ramload = ld;
        bus.ramstate = done ? ACCESS : ($urandom_range(0, 1) ? BUSY : FREE);
        bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
        #1;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== {xr, xw, done & (kind == 0), done & (kind != 0)} ||
            bus.ramaddr !== a || bus.ramstore !== d ||
            bus.iload !== ((done && kind == 0) ? ld : 32'h0) ||
            bus.dload !== ((done && kind == 1) ? ld : 32'h0) || bus.memerr !== 1'b0) begin
          bad++; $display("FAIL rnd_xfer t=%0d j=%0d k=%0d got=%b addr=%h st=%h il=%h dl=%h want=%b addr=%h st=%h ld=%h",
            t, j, kind, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, bus.ramaddr, bus.ramstore,
            bus.iload, bus.dload, {xr, xw, done & (kind == 0), done & (kind != 0)}, a, d, ld);
        end
      end
      @(negedge CLK); idle_inputs(); #1;
      total++;
      if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== 4'b0 || bus.ramaddr !== 0) begin
        bad++; $display("FAIL rnd_done t=%0d got=%b want=0000", t, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit});
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    idle_inputs();
    test_reset();
    test_ifetch();
    test_dual();
    test_rw_both();
    test_error();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
